// File: rtl/csi_y_packer.sv
// rtl/csi_y_packer.sv - packs luma bytes of a UYVY stream into framed 64-bit words
module csi_y_packer #(
    parameter int WDT        = 640,
    parameter int HGT        = 480,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_tuser,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic [15:0] s_tdata,
    input  logic        s_tlast,
    output logic        m_tuser,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [63:0] m_tdata,
    output logic        m_tlast,
    output logic        line_err,
    output logic        sof_err,
    output logic        frame_done
);

    localparam int CW = (WDT > 1) ? $clog2(WDT) : 1;
    localparam int RW = (HGT > 1) ? $clog2(HGT) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = PW + 1;

    typedef enum logic [1:0] {WAIT_SOF, ACTIVE, DROP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [2:0]      bcnt_q, bcnt_d;
    logic [55:0]     pack_q, pack_d;
    logic            pend_q, pend_d;
    logic [63:0]     pend_data_q, pend_data_d;
    logic            pend_user_q, pend_user_d;
    logic            pend_last_q, pend_last_d;
    logic            done_q, done_d;
    logic            s_tready_q, s_tready_d;
    logic [NW-1:0]   count_q, count_d;
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [65:0]     mem_q [FIFO_DEPTH];

    logic            accept;
    logic            restart;
    logic            process_beat;
    logic            line_end;
    logic            pop;
    logic [CW-1:0]   ec;
    logic [RW-1:0]   er;
    logic [2:0]      eb;
    logic [7:0]      y;
    logic [NW-1:0]   occ;
    logic            unused_chroma;

    assign unused_chroma = ^s_tdata[7:0];
    assign y             = s_tdata[15:8];
    assign accept        = s_tvalid & s_tready_q;
    // A start-of-frame beat restarts packing unless it is already pixel 0 of an active frame.
    assign restart       = accept & s_tuser &
                           ((state_q != ACTIVE) || (row_q != '0) || (col_q != '0));
    assign process_beat  = accept & ((state_q == ACTIVE) | s_tuser);
    assign ec            = restart ? '0 : col_q;
    assign er            = restart ? '0 : row_q;
    assign eb            = restart ? '0 : bcnt_q;
    assign line_end      = (ec == CW'(WDT - 1));
    assign pop           = m_tvalid & m_tready;

    // Packing / framing next-state logic, error pulses and FIFO occupancy.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        bcnt_d      = bcnt_q;
        pack_d      = pack_q;
        pend_d      = 1'b0;
        pend_data_d = pend_data_q;
        pend_user_d = pend_user_q;
        pend_last_d = pend_last_q;
        done_d      = 1'b0;
        line_err    = 1'b0;
        sof_err     = restart & (state_q == ACTIVE);

        if (process_beat) begin
            if (s_tlast && !line_end) begin
                // Early end of line: partial word is dropped with the rest of the frame.
                line_err = 1'b1;
                state_d  = DROP;
                col_d    = '0;
                row_d    = '0;
                bcnt_d   = '0;
            end else begin
                if (eb == 3'd7) begin
                    pend_d      = 1'b1;
                    pend_data_d = {y, pack_q};
                    pend_user_d = (er == '0) && (ec == CW'(7));
                    pend_last_d = line_end;
                end else begin
                    for (int i = 0; i < 7; i++) begin
                        if (eb == 3'(i)) begin
                            pack_d[i*8 +: 8] = y;
                        end
                    end
                end
                if (line_end) begin
                    col_d  = '0;
                    bcnt_d = '0;
                    if (!s_tlast) begin
                        line_err = 1'b1;
                        state_d  = DROP;
                        row_d    = '0;
                    end else if (er == RW'(HGT - 1)) begin
                        done_d  = 1'b1;
                        row_d   = '0;
                        state_d = WAIT_SOF;
                    end else begin
                        row_d   = er + 1'b1;
                        state_d = ACTIVE;
                    end
                end else begin
                    col_d   = ec + 1'b1;
                    bcnt_d  = eb + 1'b1;
                    row_d   = er;
                    state_d = ACTIVE;
                end
            end
        end

        count_d    = count_q + NW'(pend_q) - NW'(pop);
        occ        = count_d + NW'(pend_d);
        s_tready_d = (state_d != ACTIVE) || (occ < NW'(FIFO_DEPTH));
    end

    // Control, packing and FIFO pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_SOF;
            col_q       <= '0;
            row_q       <= '0;
            bcnt_q      <= '0;
            pack_q      <= '0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            pend_user_q <= 1'b0;
            pend_last_q <= 1'b0;
            done_q      <= 1'b0;
            s_tready_q  <= 1'b0;
            count_q     <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            bcnt_q      <= bcnt_d;
            pack_q      <= pack_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            pend_user_q <= pend_user_d;
            pend_last_q <= pend_last_d;
            done_q      <= done_d;
            s_tready_q  <= s_tready_d;
            count_q     <= count_d;
            if (pend_q) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    // FIFO storage; contents are only visible through count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (pend_q) begin
            mem_q[wptr_q] <= {pend_user_q, pend_last_q, pend_data_q};
        end
    end

    assign s_tready   = s_tready_q;
    assign m_tvalid   = (count_q != '0);
    assign {m_tuser, m_tlast, m_tdata} = m_tvalid ? mem_q[rptr_q] : 66'd0;
    assign frame_done = done_q;

endmodule

// File: tb/tb_csi_y_packer.sv
// tb/tb_csi_y_packer.sv - randomized self-checking bench for csi_y_packer
module tb_csi_y_packer;

    localparam int WDT   = 16;
    localparam int HGT   = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_tuser, s_tvalid, s_tready, s_tlast;
    logic [15:0] s_tdata;
    logic        m_tuser, m_tvalid, m_tready, m_tlast;
    logic [63:0] m_tdata;
    logic        line_err, sof_err, frame_done;

    csi_y_packer #(.WDT(WDT), .HGT(HGT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .s_tuser(s_tuser), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tdata(s_tdata), .s_tlast(s_tlast),
        .m_tuser(m_tuser), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tdata(m_tdata), .m_tlast(m_tlast),
        .line_err(line_err), .sof_err(sof_err), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: frame/line position in plain integers, bytes of the word in a queue.
    bit          m_active;
    int          m_pos, m_line;
    logic [7:0]  m_bytes[$];
    logic [65:0] exp_q[$];
    logic [65:0] obs_q[$];
    int          exp_done, obs_done, obs_le, obs_se;

    task automatic model_beat(input logic u, input logic l, input logic [7:0] yv,
                              output logic le, output logic se);
        logic [63:0] d;
        le = 1'b0;
        se = 1'b0;
        if (u && !(m_active && m_line == 0 && m_pos == 0)) begin
            se       = m_active;
            m_active = 1'b1;
            m_line   = 0;
            m_pos    = 0;
            m_bytes.delete();
        end
        if (!m_active) return;
        if (l && m_pos != WDT - 1) begin
            le       = 1'b1;
            m_active = 1'b0;
            m_bytes.delete();
            return;
        end
        m_bytes.push_back(yv);
        if (m_bytes.size() == 8) begin
            for (int i = 0; i < 8; i++) d[8*i +: 8] = m_bytes[i];
            exp_q.push_back({(m_line == 0 && m_pos == 7), (m_pos == WDT - 1), d});
            m_bytes.delete();
        end
        if (m_pos == WDT - 1) begin
            if (l) begin
                m_pos = 0;
                if (m_line == HGT - 1) begin
                    exp_done++;
                    m_active = 1'b0;
                    m_line   = 0;
                end else begin
                    m_line++;
                end
            end else begin
                le       = 1'b1;
                m_active = 1'b0;
            end
        end else begin
            m_pos++;
        end
    endtask

    logic        mon_le, mon_se, prev_hold;
    logic [65:0] prev_word, mon_w;

    // Monitor: samples on the falling edge, feeds accepted beats to the model, checks outputs.
    always @(negedge clk) begin
        if (rst) begin
            m_active  = 1'b0;
            m_pos     = 0;
            m_line    = 0;
            m_bytes.delete();
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            if (s_tvalid && s_tready) begin
                model_beat(s_tuser, s_tlast, s_tdata[15:8], mon_le, mon_se);
                chk("line_err", 66'(line_err), 66'(mon_le));
                chk("sof_err", 66'(sof_err), 66'(mon_se));
            end else begin
                chk("line_err_idle", 66'(line_err), 66'd0);
                chk("sof_err_idle", 66'(sof_err), 66'd0);
            end
            if (line_err) obs_le++;
            if (sof_err) obs_se++;
            if (frame_done) obs_done++;
            if (prev_hold) begin
                chk("hold_valid", 66'(m_tvalid), 66'd1);
                chk("hold_word", {m_tuser, m_tlast, m_tdata}, prev_word);
            end
            if (m_tvalid && m_tready) begin
                obs_q.push_back({m_tuser, m_tlast, m_tdata});
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {m_tuser, m_tlast, m_tdata}, 66'd0);
                end else begin
                    mon_w = exp_q.pop_front();
                    chk("word", {m_tuser, m_tlast, m_tdata}, mon_w);
                end
            end
            prev_hold = m_tvalid && !m_tready;
            prev_word = {m_tuser, m_tlast, m_tdata};
        end
    end

    // Downstream ready: 0 = always ready, 1 = random, 2 = held low.
    int mode = 0;
    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       m_tready = 1'b1;
                1:       m_tready = ($urandom_range(0, 2) != 0);
                default: m_tready = 1'b0;
            endcase
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic u, input logic l, input logic [7:0] yv);
        int   n;
        logic acc;
        n        = 0;
        s_tvalid = 1'b1;
        s_tuser  = u;
        s_tlast  = l;
        s_tdata  = {yv, 8'($urandom)};
        do begin
            @(negedge clk);
            acc = s_tready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 500);
        if (!acc) chk("s_tready_timeout", 66'd0, 66'd1);
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_frame(input int base, input bit burst);
        for (int p = 0; p < WDT * HGT; p++) begin
            send_beat(p == 0, (p % WDT) == WDT - 1, 8'(base + p));
            if (burst && (p % 4) == 3) idle(8);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_tvalid) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", 66'(n < 3000), 66'd1);
        idle(3);
        chk("frame_done_count", 66'(obs_done), 66'(exp_done));
    endtask

    function automatic logic [63:0] ramp(input int b);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = 8'(b + i);
        return r;
    endfunction

    logic [65:0] gold[4];
    int          n;

    initial begin
        gold[0] = {2'b10, 64'h0706050403020100};
        gold[1] = {2'b01, 64'h0F0E0D0C0B0A0908};
        gold[2] = {2'b00, 64'h1716151413121110};
        gold[3] = {2'b01, 64'h1F1E1D1C1B1A1918};
        exp_done = 0; obs_done = 0; obs_le = 0; obs_se = 0;
        rst = 1'b1; s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; s_tdata = '0;
        idle(3);
        chk("rst_s_tready", 66'(s_tready), 66'd0);
        chk("rst_m_tvalid", 66'(m_tvalid), 66'd0);
        chk("rst_m_word", {m_tuser, m_tlast, m_tdata}, 66'd0);
        chk("rst_pulses", {63'd0, line_err, sof_err, frame_done}, 66'd0);
        rst = 1'b0;
        idle(1);
        chk("s_tready_after_rst", 66'(s_tready), 66'd1);

        // Junk before the first start of frame, then a clean ramp frame.
        for (int i = 0; i < 3; i++) send_beat(1'b0, i == 2, 8'(8'hE0 + i));
        obs_q.delete();
        send_frame(0, 1'b0);
        drain();
        chk("s1_nwords", 66'(obs_q.size()), 66'd4);
        for (int i = 0; i < 4; i++) chk("s1_gold", obs_q[i], gold[i]);
        chk("s1_done", 66'(obs_done), 66'd1);

        // Bursty input with a 20-cycle downstream stall mid-line.
        obs_q.delete();
        fork
            send_frame(0, 1'b1);
            begin
                idle(30);
                mode = 2;
                idle(20);
                mode = 0;
            end
        join
        drain();
        chk("s2_nwords", 66'(obs_q.size()), 66'd4);
        for (int i = 0; i < 4; i++) chk("s2_gold", obs_q[i], gold[i]);

        // Backpressure: s_tready must drop with exactly DEPTH words queued.
        mode = 2;
        fork
            begin
                send_frame(8'h40, 1'b0);
                send_frame(8'h60, 1'b0);
            end
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (s_tready && n < 300);
                chk("s3_stall_seen", 66'(s_tready), 66'd0);
                chk("s3_queued", 66'(exp_q.size()), 66'(DEPTH));
                idle(10);
                mode = 0;
            end
        join
        drain();

        // Early s_tlast at col 10 of line 0, rest of frame dropped.
        obs_q.delete();
        obs_le = 0;
        for (int p = 0; p <= 10; p++) send_beat(p == 0, p == 10, 8'(p));
        for (int p = 0; p < WDT; p++) send_beat(1'b0, p == WDT - 1, 8'(8'h30 + p));
        send_frame(8'h80, 1'b0);
        drain();
        chk("s4_nwords", 66'(obs_q.size()), 66'd5);
        chk("s4_first", obs_q[0], {2'b10, ramp(0)});
        chk("s4_next_sof", obs_q[1], {2'b10, ramp(8'h80)});
        chk("s4_line_err", 66'(obs_le), 66'd1);

        // Unexpected s_tuser at row 1, col 3.
        obs_q.delete();
        obs_se = 0;
        for (int p = 0; p < WDT + 3; p++) send_beat(p == 0, p == WDT - 1, 8'(8'h10 + p));
        send_frame(8'hA0, 1'b0);
        drain();
        chk("s5_nwords", 66'(obs_q.size()), 66'd6);
        chk("s5_restart", obs_q[2], {2'b10, 64'hA7A6A5A4A3A2A1A0});
        chk("s5_sof_err", 66'(obs_se), 66'd1);

        // Random frames with random gaps, rare framing faults and random backpressure.
        mode = 1;
        for (int f = 0; f < 6; f++) begin
            for (int p = 0; p < WDT * HGT; p++) begin
                send_beat((p == 0) || ($urandom_range(0, 96) == 0),
                          (((p % WDT) == WDT - 1) ^ ($urandom_range(0, 82) == 0)),
                          8'($urandom));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 4));
            end
        end
        mode = 0;
        drain();

        // Reset with two words queued and downstream stalled.
        mode = 2;
        for (int p = 0; p < WDT; p++) send_beat(p == 0, p == WDT - 1, 8'(8'h50 + p));
        idle(4);
        chk("s7_queued", 66'(exp_q.size()), 66'd2);
        chk("s7_valid_before", 66'(m_tvalid), 66'd1);
        rst = 1'b1;
        idle(1);
        chk("s7_valid_after_rst", 66'(m_tvalid), 66'd0);
        rst = 1'b0;
        mode = 0;
        obs_q.delete();
        send_frame(8'hC0, 1'b0);
        drain();
        chk("s7_nwords", 66'(obs_q.size()), 66'd4);
        chk("s7_first", obs_q[0], {2'b10, ramp(8'hC0)});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/csi_y_packer.md
# csi_y_packer

Downstream consumer of the CSI camera AXI4-Stream (16-bit UYVY, one pixel per beat). Extracts the luma byte of each pixel, packs 8 consecutive Y bytes into a 64-bit word, and re-emits frame/line-framed 64-bit words toward the DMA write path. Checks line and frame geometry against the configured image size. Resynchronises on the next start-of-frame after any framing error.

## Interface
- WDT, 640, active pixels per line; must be a multiple of 8
- HGT, 480, active lines per frame
- FIFO_DEPTH, 4, output word FIFO entries; power of two, at least 2

- clk  in  1  single clock for all logic
- rst  in  1  synchronous, active-high reset
- s_tuser  in  1  start of frame; valid on the first pixel of a frame
- s_tvalid  in  1  input beat valid
- s_tready  out  1  input beat accepted when s_tvalid & s_tready
- s_tdata  in  16  {Y, C}; Y = s_tdata[15:8]; C is ignored
- s_tlast  in  1  last pixel of a line
- m_tuser  out  1  first word of a frame
- m_tvalid  out  1  output word valid
- m_tready  in  1  downstream ready
- m_tdata  out  64  8 Y bytes; earliest pixel in [7:0], latest in [63:56]
- m_tlast  out  1  last word of a line
- line_err  out  1  one-cycle pulse on a line-length violation
- sof_err  out  1  one-cycle pulse on an unexpected s_tuser
- frame_done  out  1  one-cycle pulse when the last word of line HGT-1 is pushed

## Operation
- The block has three states: WAIT_SOF, ACTIVE and DROP. Reset state is WAIT_SOF.
- Counters:
  - col: 0..WDT-1
  - row: 0..HGT-1
  - bcnt: 0..7, the byte slot in the word being packed
- Accepted beat in ACTIVE:
  - Y is written to byte slot bcnt.
  - When bcnt==7, the word is pushed to the FIFO. Its tuser is (row==0 & col==7) and its tlast is (col==WDT-1).
- Line end, where col==WDT-1 on an accepted beat:
  - If s_tlast=1: col←0. If row==HGT-1, frame_done pulses, row←0 and the state goes to WAIT_SOF. Otherwise row increments.
  - If s_tlast=0: line_err pulses, the word is still pushed (with tlast), and the state goes to DROP.
- Early s_tlast (col<WDT-1): line_err pulses, the partial word is discarded, and the state goes to DROP.
- s_tuser=1 in ACTIVE when not at row 0 / col 0:
  - sof_err pulses and the partial word is discarded.
  - The beat is treated as pixel 0 of a new frame: col=0, row=0, bcnt=0.
- WAIT_SOF and DROP:
  - Beats are accepted and discarded, with s_tready=1 regardless of the FIFO.
  - A beat with s_tuser=1 goes to ACTIVE and is consumed as pixel 0.
  - An error pulse and its state change occur in the same cycle as the offending beat.
- Entering DROP clears col, row and bcnt.

## Timing
- Reset values:
  - s_tready=0, m_tvalid=0, m_tuser=0, m_tlast=0, m_tdata=0.
  - All error and done pulses are 0.
  - FIFO empty, state WAIT_SOF.
  - s_tready goes high the first cycle after rst deasserts.
- s_tready in ACTIVE is (FIFO count < FIFO_DEPTH), registered. A beat is never lost when the FIFO fills.
- Latency: the 8th byte is accepted at edge N, and the word has m_tvalid=1 after edge N+1 when the FIFO was empty.
- Output is AXI4-Stream compliant:
  - m_tdata, m_tuser and m_tlast are stable while m_tvalid & ~m_tready.
  - m_tvalid does not depend combinationally on m_tready.
- A simultaneous push and pop on a full FIFO is allowed; the count is unchanged.
- Full throughput is one pixel per clock. This is sustained when m_tready=1 at least 1/8 of cycles.
- rst mid-frame:
  - The FIFO is flushed, with no partial or stale words emitted.
  - The block returns to WAIT_SOF, and the next s_tuser starts a clean frame.
- Sparse input is handled identically to dense input, e.g. 4 beats then 8 idle cycles, or s_tvalid gaps at any point.

## Test plan
- WDT=16, HGT=2, Y = pixel index 0..31, m_tready=1:
  - Four words are produced: 0x0706050403020100 (tuser=1), 0x0F0E0D0C0B0A0908 (tlast=1), then two more with tlast on the 4th.
  - frame_done pulses once.
- Same frame with input in 4-beat bursts and 8 idle cycles, and m_tready held 0 for 20 cycles mid-line:
  - The word sequence is identical and no beat is lost.
  - s_tready drops after FIFO_DEPTH words.
- s_tlast at col=10 on line 0:
  - line_err pulses that cycle.
  - No word from the partial line is emitted after the first full word.
  - The rest of the frame is dropped until the next s_tuser.
- s_tuser at row 1, col 3:
  - sof_err pulses.
  - The next emitted word has m_tuser=1 and contains the new frame's pixels 0..7.
- Beats before the first s_tuser after reset are discarded with s_tready=1, and the first output word carries m_tuser=1.
- Assert rst while 2 words are queued and m_tready=0:
  - m_tvalid=0 the cycle after.
  - The next frame's first word is emitted with tuser=1.
